sklansky_sub8_pipe: RTL and testbench
=====================================

# sklansky_sub8_pipe

- 2-stage pipelined 8-bit subtractor: computes `diff = a - b - bin`, with borrow-out, zero and signed-overflow flags.
- Reuses the PG cells, the 8-bit Sklansky prefix network and the sum cells of the adder datapath, built as `a + ~b + ~bin`.
- Has a valid/ready handshake on input and output, so it can sit between registered producers and consumers in the datapath.

## Interface
- Parameters: none. Width is fixed at 8 to match the 9-pin prefix network (pin 0 = carry-in).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand set on `a`, `b`, `bin` is valid
- `in_ready`  out  1  block accepts the operand set this cycle
- `a`  in  8  minuend
- `b`  in  8  subtrahend
- `bin`  in  1  borrow-in
- `out_valid`  out  1  result fields are valid
- `out_ready`  in  1  consumer accepts the result this cycle
- `diff`  out  8  `a - b - bin` modulo 256
- `bout`  out  1  borrow-out: 1 when unsigned `a < b + bin`
- `zero`  out  1  `diff == 8'h00`
- `ovf`  out  1  two's-complement overflow of the subtraction

## Operation
- Input transfer happens when `in_valid & in_ready`. Output transfer happens when `out_valid & out_ready`.
- Stage 1 (S1) register, loaded on input transfer:
  - PG from `a[i]` and `~b[i]`; pin 0 G = `~bin`, pin 0 P = 0.
  - Captured values: prefix group generates G[0..7], raw P[1..8], G[8], `a[7]`, `b[7]`, and `s1_valid`.
- Stage 2 (S2) register, loaded from S1 when S1 advances:
  - `diff[i] = P[i+1] ^ G[i]`
  - carry = `G[8] | (P[8] & G[7])`
  - `bout = ~carry`
  - `zero = ~|diff`
  - `ovf = (a[7] ^ b[7]) & (diff[7] ^ a[7])`
- Advance and ready logic:
  - `s2_adv = ~s2_valid | out_ready`
  - `s1_adv = s1_valid & s2_adv`
  - `in_ready = ~s1_valid | s2_adv` (combinational; no path from `in_valid`)
- Valid bookkeeping:
  - `s1_valid` next = input transfer ? 1 : (s1_adv ? 0 : hold).
  - `s2_valid` next = `s1_adv` ? 1 : (output transfer ? 0 : hold).
- Stall: data registers hold while their stage is valid and not advancing. Outputs are stable while `out_valid & ~out_ready`.
- Arithmetic: all 8-bit results wrap modulo 256. `bin` is treated as an unsigned 0/1 term.
- Do not compute `diff` from the registered prefix outputs in a way that bypasses S2: outputs come only from S2 flops.

## Timing
- Reset (asynchronous, `rst_n = 0`):
  - `s1_valid = 0`, `s2_valid = 0`, `out_valid = 0`.
  - `diff = 8'h00`, `bout = 0`, `zero = 0`, `ovf = 0`.
  - `in_ready = 1` immediately after reset deassertion.
- Latency: a result accepted at edge N shows `out_valid = 1` after edge N+1, given no stall.
- Throughput: one operation per clock while `out_ready = 1`.
- Simultaneous events:
  - When S2 drains and S1 advances on the same edge, S2 is reloaded and `out_valid` stays 1.
  - When input transfer and S1 advance occur on the same edge, S1 is reloaded and `s1_valid` stays 1.
- Full: both stages valid and `out_ready = 0` gives `in_ready = 0`. Capacity is exactly 2 in-flight operations; nothing is dropped or duplicated.
- Empty: with `in_valid = 0`, `out_valid` falls the cycle after the last result transfers.
- Reset mid-operation: all in-flight operations are discarded and `out_valid` drops asynchronously. There is no partial result after reset release.
- `in_valid` may drop without a transfer. The block never depends on `in_valid` being held.

## Test plan
- Borrow case: `a=8'h00, b=8'h01, bin=0`, `out_ready=1` -> 2 cycles later `diff=8'hFF, bout=1, zero=0, ovf=0`.
- Signed overflow: `a=8'h80, b=8'h01, bin=0` -> `diff=8'h7F, bout=0, ovf=1`. Also `a=8'h7F, b=8'hFF` -> `diff=8'h80, bout=1, ovf=1`.
- Borrow-in and zero: `a=8'h10, b=8'h0F, bin=1` -> `diff=8'h00, zero=1, bout=0`. Also `a=8'h05, b=8'h05, bin=1` -> `diff=8'hFF, bout=1`.
- Backpressure: stream 5 back-to-back ops (`a = 8'h20..8'h24`, `b = 8'h01`) with `out_ready=0` for cycles 2-6.
  - `in_ready` must drop after 2 acceptances.
  - Outputs must hold stable while stalled.
  - After release, results must arrive in order: `8'h1F..8'h23`, with no loss or repeats.
- Reset mid-stream: assert `rst_n=0` with both stages valid -> `out_valid=0` and flags=0 at once. After release, `in_ready=1` and the first new op returns its correct result with 2-cycle latency.
- Random: 10k random `{a,b,bin}` with random `in_valid`/`out_ready` -> every result matches the reference model `(a - b - bin) & 8'hFF`, and `bout = (a < b + bin)`.

Source files
------------

// File: rtl/sklansky_sub8_pipe.sv
// rtl/sklansky_sub8_pipe.sv - 2-stage 8-bit subtractor, a + ~b + ~bin on a Sklansky prefix network
// Prefix pins 0..7 feed the Sklansky tree (pin 0 = carry-in); pin 8 is kept raw for the final carry.
module sklansky_sub8_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       bin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] diff,
   output logic       bout,
   output logic       zero,
   output logic       ovf
);

   logic [7:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3;
   logic       w_g8, w_p8;
   logic       w_unused;
   logic       w_s2_adv, w_s1_adv, w_in_xfer, w_out_xfer;
   logic       w_carry;
   logic [7:0] w_diff;

   logic       r_s1_valid, r_s2_valid;
   logic [7:0] r_s1_g;
   logic [7:0] r_s1_p;
   logic       r_s1_g8, r_s1_a7, r_s1_b7;
   logic [7:0] r_diff;
   logic       r_bout, r_zero, r_ovf;

   assign w_g0[0] = ~bin;
   assign w_p0[0] = 1'b0;
   assign w_g0[7:1] = a[6:0] & ~b[6:0];
   assign w_p0[7:1] = a[6:0] ^ ~b[6:0];
   assign w_g8 = a[7] & ~b[7];
   assign w_p8 = a[7] ^ ~b[7];

   // Sklansky levels: pin i combines with the top pin of the preceding 2^l block
   for (genvar i = 0; i < 8; i++) begin : g_lvl1
      if (i[0]) begin : g_c
         assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
         assign w_p1[i] = w_p0[i] & w_p0[i-1];
      end else begin : g_t
         assign w_g1[i] = w_g0[i];
         assign w_p1[i] = w_p0[i];
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_lvl2
      localparam int J = ((i >> 1) << 1) - 1;
      if (i[1]) begin : g_c
         assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[J]);
         assign w_p2[i] = w_p1[i] & w_p1[J];
      end else begin : g_t
         assign w_g2[i] = w_g1[i];
         assign w_p2[i] = w_p1[i];
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_lvl3
      if (i[2]) begin : g_c
         assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[3]);
      end else begin : g_t
         assign w_g3[i] = w_g2[i];
      end
   end

   // Group propagates of the low half are not needed past the last level
   assign w_unused = ^w_p2[3:0];

   assign w_s2_adv   = ~r_s2_valid | out_ready;
   assign w_s1_adv   = r_s1_valid & w_s2_adv;
   assign in_ready   = ~r_s1_valid | w_s2_adv;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_s2_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_g     <= 8'h00;
         r_s1_p     <= 8'h00;
         r_s1_g8    <= 1'b0;
         r_s1_a7    <= 1'b0;
         r_s1_b7    <= 1'b0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_g     <= w_g3;
         r_s1_p     <= {w_p8, w_p0[7:1]};
         r_s1_g8    <= w_g8;
         r_s1_a7    <= a[7];
         r_s1_b7    <= b[7];
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // r_s1_p[k] holds raw P of pin k+1, so diff[k] = P[k+1] ^ G[k]
   assign w_diff  = r_s1_p ^ r_s1_g;
   assign w_carry = r_s1_g8 | (r_s1_p[7] & r_s1_g[7]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_diff     <= 8'h00;
         r_bout     <= 1'b0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_valid <= 1'b1;
         r_diff     <= w_diff;
         r_bout     <= ~w_carry;
         r_zero     <= ~|w_diff;
         r_ovf      <= (r_s1_a7 ^ r_s1_b7) & (w_diff[7] ^ r_s1_a7);
      end else if (w_out_xfer) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign out_valid = r_s2_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign zero      = r_zero;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_sklansky_sub8_pipe.sv
// tb/tb_sklansky_sub8_pipe.sv - randomized and directed checks against a plain-arithmetic subtractor model
module tb_sklansky_sub8_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       bin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] diff;
   logic       bout, zero, ovf;

   int tests = 0;
   int fails = 0;
   int n_acc = 0;

   logic [10:0] q[$];
   logic [7:0]  got[$];
   logic        held_v = 1'b0;
   logic [10:0] held;
   logic [10:0] exp_r;

   sklansky_sub8_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Result packed as {bout, zero, ovf, diff}
   function automatic logic [10:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
      int d, sd;
      d  = int'(x) - int'(y) - int'(c);
      sd = int'($signed(x)) - int'($signed(y)) - int'(c);
      return {d < 0, (d & 255) == 0, (sd < -128) || (sd > 127), 8'(d)};
   endfunction

   always @(negedge rst_n) begin
      q.delete();
      held_v = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready_model", in_ready, (q.size() < 2) || out_ready);
         if (q.size() == 0) check("out_valid_empty", out_valid, 0);
         if (q.size() == 2) check("out_valid_full", out_valid, 1);
         if (held_v) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {bout, zero, ovf, diff}, held);
         end
         held_v = out_valid & ~out_ready;
         held   = {bout, zero, ovf, diff};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_result", 1, 0);
            end else begin
               exp_r = q.pop_front();
               check("result", {bout, zero, ovf, diff}, exp_r);
               got.push_back(diff);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_sub(a, b, bin));
            n_acc++;
         end
      end
   end

   task automatic run_one(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
      @(posedge clk); #1;
      a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
      #2 check("dir_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("dir_lat_early", out_valid, 0);
      @(posedge clk); #1;
      check("dir_out_valid", out_valid, 1);
      check("dir_diff", diff, ed);
      check("dir_flags", {bout, zero, ovf}, {eb, ez, eo});
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_fields", {bout, zero, ovf, diff}, 0);
      #5 rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);

      run_one(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_one(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
      run_one(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
      run_one(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      run_one(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Backpressure: five back-to-back ops, consumer stalled for cycles 1..5
      got.delete();
      begin
         int idx;
         logic acc;
         idx = 0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid  = (idx < 5);
            a         = 8'h20 + 8'(idx);
            b         = 8'h01;
            bin       = 1'b0;
            out_ready = !(cyc >= 1 && cyc <= 5);
            #2;
            acc = in_valid & in_ready;
            if (cyc == 3) begin
               check("bp_in_ready_low", in_ready, 0);
               check("bp_accepted", 16'(idx), 2);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx == 5 && got.size() == 5) break;
         end
         in_valid = 1'b0;
         check("bp_count", 16'(got.size()), 5);
         for (int k = 0; k < 5; k++)
            if (k < got.size()) check("bp_order", got[k], 8'h1F + 8'(k));
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'h44; b = 8'h04; bin = 1'b0;
      @(posedge clk); #1;
      a = 8'h55; b = 8'h05;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 check("mid_full_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_fields", {bout, zero, ovf, diff}, 0);
      #3 rst_n = 1'b1;
      #1 check("mid_rel_in_ready", in_ready, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("mid_no_partial", out_valid, 0);
      run_one(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Random traffic
      begin
         int start_acc;
         int cyc;
         start_acc = n_acc;
         cyc = 0;
         while ((n_acc - start_acc) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            bin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
         end
         check("rand_done", 16'((n_acc - start_acc) >= 10000), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("drain_queue", 16'(q.size()), 0);
      check("drain_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
